// File: rtl/if4_alu_sched_pkg.sv
// if4_sched_pkg: shared FSM state enumeration and ALU opcodes for if4_alu_sched
package if4_sched_pkg;
  typedef enum logic [3:0] {IDLE, T1, T2, T3, E1, E2, E3, E4, E5, E6, DONE} state_t;
  typedef enum logic [2:0] {ADD, SUB, MUL, GT, SEL} alu_op_t;
endpackage

// File: rtl/if4_alu_sched_if.sv
// if4_alu_sched_if: request/result bundle (Start, t, a, b, c, one in; Done, Busy, x, z out); master=requester, slave=scheduler
interface if4_alu_sched_if #(parameter int DATA_W = 32);
  logic Start;
  logic t;
  logic signed [DATA_W-1:0] a, b, c, one;
  logic Done;
  logic Busy;
  logic signed [DATA_W-1:0] x, z;
  modport master(output Start, t, a, b, c, one, input Done, Busy, x, z);
  modport slave(input Start, t, a, b, c, one, output Done, Busy, x, z);
endinterface

// File: rtl/if4_alu_sched_alu.sv
// shared_alu: combinational ALU (op, p, q, sel -> y); add/sub/mul wrap to DATA_W, GT is a signed compare, SEL picks p when sel else q
module shared_alu
  import if4_sched_pkg::*;
#(parameter int DATA_W = 32) (
  input  alu_op_t                  op,
  input  logic signed [DATA_W-1:0] p,
  input  logic signed [DATA_W-1:0] q,
  input  logic                     sel,
  output logic signed [DATA_W-1:0] y
);
  always_comb
    y = op == ADD ? p + q :
        op == SUB ? p - q :
        op == MUL ? p * q :
        op == GT  ? DATA_W'(p > q) :
        sel       ? p : q;
endmodule

// File: rtl/if4_alu_sched.sv
// if4_alu_sched: one-ALU scheduler for x/z of the if4 computation; ports Clk, Rst (async high), bus (slave: Start,t,a,b,c,one -> Done,Busy,x,z)
module if4_alu_sched
  import if4_sched_pkg::*;
#(parameter int DATA_W = 32) (
  input logic             Clk,
  input logic             Rst,
  if4_alu_sched_if.slave  bus
);
  state_t state, state_n;
  alu_op_t op;
  logic signed [DATA_W-1:0] a_q, b_q, c_q, one_q, d, e, f, x_q, z_q, p, q, y;
  logic g;
  shared_alu #(.DATA_W(DATA_W)) u_alu (.op(op), .p(p), .q(q), .sel(g), .y(y));
  assign bus.Done = state == DONE;
  assign bus.Busy = state != IDLE;
  assign bus.x = x_q;
  assign bus.z = z_q;
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = IDLE;
    case (state)
      IDLE: state_n = bus.Start ? (bus.t ? T1 : E1) : IDLE;
      T1: state_n = T2;
      T2: state_n = T3;
      T3: state_n = DONE;
      E1: state_n = E2;
      E2: state_n = E3;
      E3: state_n = E4;
      E4: state_n = E5;
      E5: state_n = E6;
      E6: state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    op = ADD;
    p = '0;
    q = '0;
    case (state)
      T1: begin op = SUB; p = a_q; q = one_q; end
      T2: begin op = ADD; p = a_q; q = c_q; end
      T3: begin op = SUB; p = f; q = d; end
      E1: begin op = ADD; p = a_q; q = b_q; end
      E2: begin op = ADD; p = a_q; q = c_q; end
      E3: begin op = MUL; p = a_q; q = c_q; end
      E4: begin op = SUB; p = f; q = d; end
      E5: begin op = GT; p = d; q = e; end
      E6: begin op = SEL; p = d; q = e; end
      default: ;
    endcase
  end
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) begin
      {a_q, b_q, c_q, one_q, d, e, f, x_q, z_q} <= '0;
      g <= 1'b0;
    end else begin
      if (state == IDLE && bus.Start) begin
        a_q <= bus.a;
        b_q <= bus.b;
        c_q <= bus.c;
        one_q <= bus.one;
      end
      case (state)
        T1, E1: d <= y;
        E2: e <= y;
        T2, E3: f <= y;
        T3, E4: x_q <= y;
        E5: g <= y[0];
        E6: z_q <= y;
        default: ;
      endcase
    end
endmodule

// File: tb/tb_if4_alu_sched.sv
// tb_if4_alu_sched: directed self-checking bench for if4_alu_sched
module tb_if4_alu_sched;
  logic Clk = 1'b0;
  logic Rst = 1'b1;
  int tests = 0;
  int failed = 0;
  if4_alu_sched_if #(.DATA_W(32)) bus();
  if4_alu_sched #(.DATA_W(32)) dut(.Clk(Clk), .Rst(Rst), .bus(bus));
  always #5 Clk = ~Clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic run(input string tag, input logic tt, input logic [31:0] aa, bb, cc, oo,
                     input bit hold, input int lat, input logic [31:0] ex, ez);
    int n = 0;
    int busy_n = 0;
    bus.Start = 1'b1;
    bus.t = tt;
    bus.a = aa;
    bus.b = bb;
    bus.c = cc;
    bus.one = oo;
    do begin
      @(negedge Clk);
      n++;
      busy_n += int'(bus.Busy);
      if (!hold) bus.Start = 1'b0;
      bus.t = ~tt;
      bus.a = $urandom;
      bus.b = $urandom;
      bus.c = $urandom;
      bus.one = $urandom;
    end while (!bus.Done && n < 20);
    bus.Start = 1'b0;
    chk({tag, " latency"}, n, lat);
    chk({tag, " busy"}, busy_n, lat);
    chk({tag, " x"}, bus.x, ex);
    chk({tag, " z"}, bus.z, ez);
    @(negedge Clk);
    chk({tag, " done single"}, {31'b0, bus.Done}, 0);
    chk({tag, " idle"}, {31'b0, bus.Busy}, 0);
    chk({tag, " x hold"}, bus.x, ex);
  endtask
  initial begin
    bus.Start = 1'b0;
    bus.t = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.c = '0;
    bus.one = '0;
    #1;
    chk("rst done", {31'b0, bus.Done}, 0);
    chk("rst busy", {31'b0, bus.Busy}, 0);
    chk("rst x", bus.x, 0);
    chk("rst z", bus.z, 0);
    @(negedge Clk);
    Rst = 1'b0;
    run("t1 basic", 1'b1, 10, 0, 3, 1, 0, 4, 4, 0);
    run("t0 basic", 1'b0, 5, 2, 3, 1, 0, 7, 8, 8);
    run("t1 z hold", 1'b1, 20, 0, 5, 1, 0, 4, 6, 8);
    run("t0 neg", 1'b0, 6, 4, 1, 1, 0, 7, 32'hFFFF_FFFC, 10);
    run("t0 start held", 1'b0, 5, 2, 3, 1, 1, 7, 8, 8);
    run("t0 wrap", 1'b0, 32'h7FFF_FFFF, 0, 2, 1, 0, 7, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    bus.Start = 1'b1;
    bus.t = 1'b0;
    bus.a = 5;
    bus.b = 2;
    bus.c = 3;
    @(negedge Clk);
    bus.Start = 1'b0;
    repeat (2) @(negedge Clk);
    Rst = 1'b1;
    #1;
    chk("abort busy", {31'b0, bus.Busy}, 0);
    chk("abort done", {31'b0, bus.Done}, 0);
    chk("abort x", bus.x, 0);
    chk("abort z", bus.z, 0);
    @(negedge Clk);
    chk("abort held done", {31'b0, bus.Done}, 0);
    Rst = 1'b0;
    run("t1 after rst", 1'b1, 10, 0, 3, 1, 0, 4, 4, 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/if4_alu_sched.md
IF4_ALU_SCHED -- requirements
Module: if4_alu_sched

Interface
REQ-001 Parameter DATA_W, default 32, operand/result width (signed two's complement).
REQ-002 Clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Rst  input  1  asynchronous, active-high reset.
REQ-004 Start  input  1  request to run one computation; sampled only in IDLE.
REQ-005 t  input  1  branch select, latched with Start.
REQ-006 a, b, c, one  input  DATA_W each  signed operands, latched with Start.
REQ-007 Done  output  1  one-cycle completion pulse.
REQ-008 Busy  output  1  high whenever state is not IDLE.
REQ-009 x, z  output  DATA_W each  signed result registers.

Function
REQ-010 The block SHALL compute the if4 computation using exactly one shared ALU, one operation per cycle.
REQ-011 In IDLE with Start=1, the block SHALL latch t/a/b/c/one into operand registers and leave IDLE next edge; later input changes SHALL NOT affect the result.
REQ-012 Start SHALL be ignored in every non-IDLE state, including DONE.
REQ-013 The t=1 path SHALL be IDLE->T1 (d=a-one)->T2 (f=a+c)->T3 (x=f-d)->DONE->IDLE; z SHALL hold its prior value.
REQ-014 The t=0 path SHALL be IDLE->E1 (d=a+b)->E2 (e=a+c)->E3 (f=a*c)->E4 (x=f-d)->E5 (g=d>e)->E6 (z=g?d:e)->DONE->IDLE.
REQ-015 Done SHALL be high for exactly the single cycle in DONE; latency Start-edge to Done-high SHALL be 4 cycles (t=1) or 7 cycles (t=0).
REQ-016 x and z SHALL be valid and stable while Done is high and SHALL hold until overwritten by a later run.
REQ-017 Add/sub/mul SHALL wrap modulo 2^DATA_W; the product SHALL be its low DATA_W bits.
REQ-018 The compare SHALL be signed; g SHALL be a 1-bit register.
REQ-019 The ALU operation select and operand muxing SHALL be a pure function of the current state.
REQ-020 Illegal state encodings SHALL return to IDLE on the next edge with Done low.

Reset
REQ-021 On Rst: state=IDLE; x, z, d, e, f, g and operand registers = 0; Done=0; Busy=0, all immediately without waiting for a clock edge.
REQ-022 Rst mid-run SHALL abort the run with no Done pulse; a Start on the first edge after Rst deasserts SHALL be accepted.

Structure
REQ-023 A shared package if4_sched_pkg SHALL hold the state enumeration (IDLE, T1-T3, E1-E6, DONE) and ALU opcodes (ADD, SUB, MUL, GT, SEL).
REQ-024 One combinational sub-module, shared_alu (opcode, two operands, select bit -> DATA_W result), SHALL be instantiated exactly once.

Verification
REQ-025 t=1, a=10, c=3, one=1 -> x=4, z unchanged (0 after reset), Done 4 cycles after Start, single cycle.
REQ-026 t=0, a=5, b=2, c=3 -> d=7, e=8, f=15, x=8, g=0, z=8, Done 7 cycles after Start.
REQ-027 t=0, a=6, b=4, c=1 -> x=-4, g=1, z=10.
REQ-028 Start pulsed every cycle and a/b/c changed during a t=0 run -> only the first Start honoured, results per the latched values, Busy high for 7 cycles.
REQ-029 Rst asserted 3 cycles into a t=0 run -> x=z=0, Busy=0, no Done; a following t=1 run completes normally.
REQ-030 t=0, a=0x7FFFFFFF, b=0, c=2 -> f=0xFFFFFFFE, x=0x7FFFFFFF (wrap), g=1, z=0x7FFFFFFF.
